// File: rtl/hzzm_master_if.sv
// Request, write-data, read-data, status and HZZM bus signals of hzzm_master.
// The master modport is the hzzm_master view; the slave modport is its environment.
interface hzzm_master_if #(
  parameter int W = 64
);
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [53:0]  req_addr;
  logic [7:0]   req_len;
  logic         wdata_valid;
  logic         wdata_ready;
  logic [W-1:0] wdata;
  logic         rdata_valid;
  logic [W-1:0] rdata;
  logic         rdata_last;
  logic         done;
  logic         err;
  logic         busy;
  logic [W-1:0] hzzm_mosi;
  logic         hzzm_mosi_valid;
  logic         hzzm_mosi_oe;
  logic [W-1:0] hzzm_miso;
  logic         hzzm_miso_valid;

  modport master (
    input  req_valid, req_write, req_addr, req_len, wdata_valid, wdata,
           hzzm_miso, hzzm_miso_valid,
    output req_ready, wdata_ready, rdata_valid, rdata, rdata_last, done, err,
           busy, hzzm_mosi, hzzm_mosi_valid, hzzm_mosi_oe
  );

  modport slave (
    output req_valid, req_write, req_addr, req_len, wdata_valid, wdata,
           hzzm_miso, hzzm_miso_valid,
    input  req_ready, wdata_ready, rdata_valid, rdata, rdata_last, done, err,
           busy, hzzm_mosi, hzzm_mosi_valid, hzzm_mosi_oe
  );
endinterface

// File: rtl/hzzm_master.sv
// HZZM burst master: header beat, then write beats out or read beats in, with done/err pulses.
// Optional response watchdog enabled by defining HZZM_TIMEOUT_EN.
package PKG_dla_config;
  localparam int HZZ_T2D_WIDTH = 64;
endpackage

module hzzm_master #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic           clk,
  input  logic           rst_n,
  hzzm_master_if.master  bus
);
  import PKG_dla_config::*;

  localparam int W = HZZ_T2D_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    WDATA,
    WRESP,
    RDATA
  } state_t;

  state_t       state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         write_q, write_d;
  logic [W-1:0] mosi_q, mosi_d;
  logic         mosi_valid_q, mosi_valid_d;
  logic [W-1:0] rdata_q, rdata_d;
  logic         rdata_valid_q, rdata_valid_d;
  logic         rdata_last_q, rdata_last_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
  logic [W-1:0] hdr;
  logic         legal;
  logic         wAccept;

`ifdef HZZM_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] toCnt_q, toCnt_d;
`endif

  assign bus.req_ready       = (state_q == IDLE);
  assign bus.wdata_ready     = (state_q == WDATA);
  assign bus.busy            = (state_q != IDLE);
  assign bus.hzzm_mosi_oe    = (state_q != RDATA);
  assign bus.hzzm_mosi       = mosi_q;
  assign bus.hzzm_mosi_valid = mosi_valid_q;
  assign bus.rdata           = rdata_q;
  assign bus.rdata_valid     = rdata_valid_q;
  assign bus.rdata_last      = rdata_last_q;
  assign bus.done            = done_q;
  assign bus.err             = err_q;

  assign legal   = (bus.req_len[1:0] == 2'b11) && (bus.req_addr[1:0] == 2'b00);
  assign wAccept = bus.wdata_valid & bus.wdata_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      write_q       <= 1'b0;
      mosi_q        <= '0;
      mosi_valid_q  <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      rdata_last_q  <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
`ifdef HZZM_TIMEOUT_EN
      toCnt_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      write_q       <= write_d;
      mosi_q        <= mosi_d;
      mosi_valid_q  <= mosi_valid_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      rdata_last_q  <= rdata_last_d;
      done_q        <= done_d;
      err_q         <= err_d;
`ifdef HZZM_TIMEOUT_EN
      toCnt_q       <= toCnt_d;
`endif
    end
  end

  // The beat counter holds "beats remaining minus one", so len=255 yields 256 beats with no wrap.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    write_d       = write_q;
    mosi_d        = mosi_q;
    mosi_valid_d  = 1'b0;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    rdata_last_d  = 1'b0;
    done_d        = 1'b0;
    err_d         = 1'b0;
`ifdef HZZM_TIMEOUT_EN
    toCnt_d       = toCnt_q;
`endif

    hdr             = '0;
    hdr[W-1]        = bus.req_write;
    hdr[W-2]        = ~bus.req_write;
    hdr[W-3 -: 8]   = bus.req_len;
    hdr[53:0]       = bus.req_addr;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (legal) begin
            state_d      = HDR;
            write_d      = bus.req_write;
            cnt_d        = bus.req_len;
            mosi_d       = hdr;
            mosi_valid_d = 1'b1;
          end else begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end
      end
      HDR: begin
        state_d = write_q ? WDATA : RDATA;
`ifdef HZZM_TIMEOUT_EN
        toCnt_d = '0;
`endif
      end
      WDATA: begin
        if (wAccept) begin
          mosi_d       = bus.wdata;
          mosi_valid_d = 1'b1;
          if (cnt_q == 8'd0) begin
            state_d = WRESP;
`ifdef HZZM_TIMEOUT_EN
            toCnt_d = '0;
`endif
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      WRESP: begin
        if (bus.hzzm_miso_valid) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
`ifdef HZZM_TIMEOUT_EN
        else if (toCnt_q == TO_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          toCnt_d = toCnt_q + TO_W'(1);
        end
`endif
      end
      RDATA: begin
        if (bus.hzzm_miso_valid) begin
          rdata_d       = bus.hzzm_miso;
          rdata_valid_d = 1'b1;
`ifdef HZZM_TIMEOUT_EN
          toCnt_d       = '0;
`endif
          if (cnt_q == 8'd0) begin
            rdata_last_d = 1'b1;
            done_d       = 1'b1;
            state_d      = IDLE;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
`ifdef HZZM_TIMEOUT_EN
        else if (toCnt_q == TO_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          toCnt_d = toCnt_q + TO_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_hzzm_master.sv
// Randomized self-checking bench for hzzm_master; expected bus/read beats are built from the burst rules.
module tb_hzzm_master;
  localparam int W  = PKG_dla_config::HZZ_T2D_WIDTH;
  localparam int TO = 16;

  typedef struct {
    int           cyc;
    logic [W-1:0] d;
    logic         last;
  } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc      = 0;
  int   asserts  = 0;
  int   failures = 0;

  beat_t mosiQ[$];
  beat_t rdQ[$];
  int    doneQ[$];
  int    errQ[$];

  hzzm_master_if #(.W(W)) bif();

  hzzm_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor records every observable event tagged with the cycle it appeared in.
  always @(posedge clk) begin
    #2;
    if (bif.hzzm_mosi_valid) mosiQ.push_back('{cyc, bif.hzzm_mosi, 1'b0});
    if (bif.rdata_valid) rdQ.push_back('{cyc, bif.rdata, bif.rdata_last});
    if (bif.done) doneQ.push_back(cyc);
    if (bif.err) errQ.push_back(cyc);
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic clearMon();
    mosiQ.delete();
    rdQ.delete();
    doneQ.delete();
    errQ.delete();
  endtask

  task automatic idleInputs();
    bif.req_valid = 1'b0; bif.req_write = 1'b0; bif.req_addr = '0; bif.req_len = '0;
    bif.wdata_valid = 1'b0; bif.wdata = '0; bif.hzzm_miso = '0; bif.hzzm_miso_valid = 1'b0;
  endtask

  function automatic logic [W-1:0] hdrOf(input logic wr, input logic [7:0] l, input logic [53:0] a);
    logic [W-1:0] h;
    h = '0;
    h[W-1] = wr;
    h[W-2] = ~wr;
    h[W-3 -: 8] = l;
    h[53:0] = a;
    return h;
  endfunction

  task automatic issue(input logic wr, input logic [53:0] a, input logic [7:0] l, output int c);
    bif.req_valid = 1'b1; bif.req_write = wr; bif.req_addr = a; bif.req_len = l;
    c = cyc;
    step();
    bif.req_valid = 1'b0;
  endtask

  task automatic checkResetOutputs(input string nm);
    logic [8:0] got;
    got = {bif.req_ready, bif.wdata_ready, bif.rdata_valid, bif.rdata_last, bif.done,
           bif.err, bif.busy, bif.hzzm_mosi_valid, bif.hzzm_mosi_oe};
    asserts++;
    if (got !== 9'b1_0000_0001) begin
      failures++;
      $display("[TB] FAIL %s ctrl: got %b, want %b", nm, got, 9'b1_0000_0001);
    end
    asserts++;
    if (bif.rdata !== '0 || bif.hzzm_mosi !== '0) begin
      failures++;
      $display("[TB] FAIL %s data: got rdata=%h mosi=%h, want 0", nm, bif.rdata, bif.hzzm_mosi);
    end
  endtask

  task automatic runWrite(input string nm, input logic [53:0] a, input logic [7:0] l,
                          input int minGap, input int maxGap, input bit respond, output int lastC);
    beat_t exp[$];
    logic [W-1:0] d;
    int c, tries;
    logic acc;
    clearMon();
    asserts++;
    if (bif.req_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s req_ready before: got %b, want 1", nm, bif.req_ready);
    end
    issue(1'b1, a, l, c);
    exp.push_back('{c + 1, hdrOf(1'b1, l, a), 1'b0});
    for (int i = 0; i <= int'(l); i++) begin
      d = {$urandom(), $urandom()};
      bif.wdata_valid = 1'b0;
      step($urandom_range(maxGap, minGap));
      tries = 0;
      acc = 1'b0;
      while (!acc && tries < 20) begin
        bif.wdata_valid = 1'b1; bif.wdata = d;
        acc = bif.wdata_ready;
        c = cyc;
        step();
        tries++;
      end
      if (!acc) begin
        asserts++; failures++;
        $display("[TB] FAIL %s wdata accept: got no wdata_ready in 20 cycles, want accept", nm);
        break;
      end
      exp.push_back('{c + 1, d, 1'b0});
    end
    lastC = c;
    bif.wdata_valid = 1'b1; bif.wdata = {$urandom(), $urandom()};
    asserts++;
    if ({bif.wdata_ready, bif.busy, bif.hzzm_mosi_oe} !== 3'b011) begin
      failures++;
      $display("[TB] FAIL %s wresp status: got %b, want 011", nm, {bif.wdata_ready, bif.busy, bif.hzzm_mosi_oe});
    end
    step();
    bif.wdata_valid = 1'b0;
    if (respond) begin
      step($urandom_range(3, 0));
      bif.hzzm_miso_valid = 1'b1; bif.hzzm_miso = {$urandom(), $urandom()};
      c = cyc;
      step();
      bif.hzzm_miso_valid = 1'b0;
      asserts++;
      if (doneQ.size() != 1 || doneQ[0] != c + 1 || errQ.size() != 0) begin
        failures++;
        $display("[TB] FAIL %s done: got %0d pulses first@%0d errs=%0d, want 1 @%0d errs=0",
                 nm, doneQ.size(), (doneQ.size() > 0) ? doneQ[0] : -1, errQ.size(), c + 1);
      end
    end
    asserts++;
    if (mosiQ.size() != exp.size()) begin
      failures++;
      $display("[TB] FAIL %s mosi count: got %0d, want %0d", nm, mosiQ.size(), exp.size());
    end else begin
      foreach (exp[i]) begin
        asserts++;
        if (mosiQ[i].cyc != exp[i].cyc || mosiQ[i].d !== exp[i].d) begin
          failures++;
          $display("[TB] FAIL %s mosi[%0d]: got %h@%0d, want %h@%0d", nm, i,
                   mosiQ[i].d, mosiQ[i].cyc, exp[i].d, exp[i].cyc);
        end
      end
    end
  endtask

  task automatic runRead(input string nm, input logic [53:0] a, input logic [7:0] l,
                         input int maxGap, input int abortAfter);
    beat_t exp[$];
    logic [W-1:0] d;
    int c, c0;
    clearMon();
    issue(1'b0, a, l, c0);
    bif.hzzm_miso_valid = 1'b1; bif.hzzm_miso = {$urandom(), $urandom()};
    step();
    bif.hzzm_miso_valid = 1'b0;
    asserts++;
    if ({bif.hzzm_mosi_oe, bif.busy} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL %s rdata oe/busy: got %b, want 01", nm, {bif.hzzm_mosi_oe, bif.busy});
    end
    c = c0;
    for (int i = 0; i <= int'(l); i++) begin
      if (abortAfter >= 0 && i == abortAfter) break;
      step($urandom_range(maxGap, 0));
      d = {$urandom(), $urandom()};
      bif.hzzm_miso_valid = 1'b1; bif.hzzm_miso = d;
      c = cyc;
      step();
      bif.hzzm_miso_valid = 1'b0;
      exp.push_back('{c + 1, d, (i == int'(l))});
    end
    if (abortAfter < 0) begin
      bif.hzzm_miso_valid = 1'b1; bif.hzzm_miso = {$urandom(), $urandom()};
      step();
      bif.hzzm_miso_valid = 1'b0;
      step();
      asserts++;
      if (doneQ.size() != 1 || doneQ[0] != c + 1 || errQ.size() != 0) begin
        failures++;
        $display("[TB] FAIL %s done: got %0d pulses first@%0d errs=%0d, want 1 @%0d errs=0",
                 nm, doneQ.size(), (doneQ.size() > 0) ? doneQ[0] : -1, errQ.size(), c + 1);
      end
    end
    asserts++;
    if (mosiQ.size() != 1 || mosiQ[0].d !== hdrOf(1'b0, l, a) || mosiQ[0].cyc != c0 + 1) begin
      failures++;
      $display("[TB] FAIL %s header: got %0d beats first=%h, want 1 beat %h@%0d", nm, mosiQ.size(),
               (mosiQ.size() > 0) ? mosiQ[0].d : '0, hdrOf(1'b0, l, a), c0 + 1);
    end
    asserts++;
    if (rdQ.size() != exp.size()) begin
      failures++;
      $display("[TB] FAIL %s rdata count: got %0d, want %0d", nm, rdQ.size(), exp.size());
    end else begin
      foreach (exp[i]) begin
        asserts++;
        if (rdQ[i].cyc != exp[i].cyc || rdQ[i].d !== exp[i].d || rdQ[i].last !== exp[i].last) begin
          failures++;
          $display("[TB] FAIL %s rdata[%0d]: got %h last=%b @%0d, want %h last=%b @%0d", nm, i,
                   rdQ[i].d, rdQ[i].last, rdQ[i].cyc, exp[i].d, exp[i].last, exp[i].cyc);
        end
      end
    end
  endtask

  task automatic test_reset();
    step(2);
    checkResetOutputs("reset");
    rst_n = 1'b1;
    step(2);
    checkResetOutputs("after_reset");
  endtask

  task automatic test_write();
    int lc;
    runWrite("write_0x40", 54'h40, 8'd3, 0, 0, 1'b1, lc);
  endtask

  task automatic test_read();
    runRead("read_0x40", 54'h40, 8'd7, 0, -1);
  endtask

  task automatic test_illegal();
    logic [53:0] a;
    logic [7:0]  l;
    int c;
    for (int k = 0; k < 5; k++) begin
      if (k == 0) begin a = 54'h40; l = 8'd5; end
      else if (k == 1) begin a = 54'h41; l = 8'd7; end
      else begin
        do begin
          a = 54'({$urandom(), $urandom()});
          l = 8'($urandom());
        end while (l[1:0] == 2'b11 && a[1:0] == 2'b00);
      end
      clearMon();
      issue(1'($urandom()), a, l, c);
      asserts++;
      if ({bif.req_ready, bif.busy} !== 2'b10) begin
        failures++;
        $display("[TB] FAIL illegal%0d ready/busy: got %b, want 10", k, {bif.req_ready, bif.busy});
      end
      step(2);
      asserts++;
      if (mosiQ.size() != 0 || doneQ.size() != 1 || errQ.size() != 1 ||
          doneQ[0] != c + 1 || errQ[0] != c + 1) begin
        failures++;
        $display("[TB] FAIL illegal%0d: got mosi=%0d done=%0d err=%0d, want mosi=0 done=err=1 @%0d",
                 k, mosiQ.size(), doneQ.size(), errQ.size(), c + 1);
      end
    end
  endtask

  task automatic test_write_gaps();
    int lc;
    runWrite("write_gaps", 54'h40, 8'd3, 2, 2, 1'b1, lc);
  endtask

  task automatic test_reset_mid_read();
    runRead("read_abort", 54'h40, 8'd7, 1, 3);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("mid_read_reset");
    step(2);
    rst_n = 1'b1;
    step();
    asserts++;
    if (doneQ.size() != 0 || errQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL abort pulses: got done=%0d err=%0d, want 0 0", doneQ.size(), errQ.size());
    end
    runRead("read_after_reset", 54'h40, 8'd3, 1, -1);
  endtask

  task automatic test_long_read();
    logic [53:0] a;
    a = 54'({$urandom(), $urandom()});
    a[1:0] = 2'b00;
    runRead("read_len255", a, 8'd255, 0, -1);
  endtask

  task automatic test_random();
    logic [53:0] a;
    logic [7:0]  l;
    int lc;
    for (int k = 0; k < 8; k++) begin
      a = 54'({$urandom(), $urandom()});
      a[1:0] = 2'b00;
      l = 8'($urandom_range(31, 0));
      l[1:0] = 2'b11;
      if ($urandom_range(1, 0) == 1) runWrite("rand_write", a, l, 0, 2, 1'b1, lc);
      else runRead("rand_read", a, l, 2, -1);
    end
  endtask

  task automatic test_timeout();
    int lc;
    runWrite("write_noresp", 54'h100, 8'd3, 0, 0, 1'b0, lc);
`ifdef HZZM_TIMEOUT_EN
    step(TO + 4);
    asserts++;
    if (doneQ.size() != 1 || errQ.size() != 1 || doneQ[0] != lc + 1 + TO ||
        errQ[0] != lc + 1 + TO || bif.busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL timeout: got done=%0d@%0d err=%0d busy=%b, want 1@%0d err=1 busy=0",
               doneQ.size(), (doneQ.size() > 0) ? doneQ[0] : -1, errQ.size(), bif.busy, lc + 1 + TO);
    end
`else
    step(3 * TO);
    asserts++;
    if (doneQ.size() != 0 || errQ.size() != 0 || bif.busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL no_timeout: got done=%0d err=%0d busy=%b, want 0 0 1",
               doneQ.size(), errQ.size(), bif.busy);
    end
`endif
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    idleInputs();
    test_reset();
    test_write();
    test_read();
    test_illegal();
    test_write_gaps();
    test_reset_mid_read();
    test_long_read();
    test_random();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end
endmodule
